// File: rtl/rr_merge_tfifo.sv
// Round-robin merge of NUM_INPUTS handshake channels into one tagged stream
// through a shared transparent FIFO; define RR_MERGE_OCCUPANCY_EN for occupancy/full_o ports.
module rr_merge_tfifo #(
  parameter int NUM_INPUTS = 2,
  parameter int SLOTS = 2,
  parameter int DATA_WIDTH = 32,
  localparam int INDEX_WIDTH = (NUM_INPUTS > 2) ? $clog2(NUM_INPUTS) : 1,
  localparam int OCC_WIDTH = $clog2(SLOTS + 1)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
  input  logic [NUM_INPUTS-1:0]            ins_valid,
  output logic [NUM_INPUTS-1:0]            ins_ready,
  output logic [DATA_WIDTH-1:0]            outs,
  output logic [INDEX_WIDTH-1:0]           outs_index,
  output logic                             outs_valid,
  input  logic                             outs_ready
`ifdef RR_MERGE_OCCUPANCY_EN
  ,
  output logic [OCC_WIDTH-1:0]             occupancy,
  output logic                             full_o
`endif
);

  localparam int PTR_WIDTH = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [OCC_WIDTH-1:0]   FULL_COUNT = OCC_WIDTH'(SLOTS);
  localparam logic [PTR_WIDTH-1:0]   LAST_SLOT  = PTR_WIDTH'(SLOTS - 1);
  localparam logic [INDEX_WIDTH-1:0] LAST_INPUT = INDEX_WIDTH'(NUM_INPUTS - 1);

  logic [INDEX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [OCC_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]  data_mem_q [SLOTS];
  logic [INDEX_WIDTH-1:0] idx_mem_q  [SLOTS];

  logic                   grant_valid;
  logic [INDEX_WIDTH-1:0] grant;
  logic [DATA_WIDTH-1:0]  grant_data;
  logic                   empty, full, can_accept, accept, pop, push, pop_buf;

  always_comb begin
    logic [INDEX_WIDTH-1:0] cand;
    cand        = rr_ptr_q;
    grant_valid = 1'b0;
    grant       = '0;
    for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
      if (!grant_valid && ins_valid[cand]) begin
        grant_valid = 1'b1;
        grant       = cand;
      end
      cand = (cand == LAST_INPUT) ? '0 : cand + INDEX_WIDTH'(1);
    end
    grant_data = ins[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
  end

  // Handshakes are gated by rst so nothing is offered or taken while reset is low.
  always_comb begin
    empty      = (count_q == '0);
    full       = (count_q == FULL_COUNT);
    can_accept = !full || outs_ready;
    accept     = rst && grant_valid && can_accept;
    ins_ready  = '0;
    if (accept) ins_ready[grant] = 1'b1;
    if (empty) begin
      outs       = grant_data;
      outs_index = grant;
      outs_valid = rst && grant_valid;
    end else begin
      outs       = data_mem_q[head_q];
      outs_index = idx_mem_q[head_q];
      outs_valid = rst;
    end
    pop     = outs_valid && outs_ready;
    push    = accept && !(empty && pop);
    pop_buf = pop && !empty;
  end

  always_comb begin
    tail_d   = tail_q;
    head_d   = head_q;
    rr_ptr_d = rr_ptr_q;
    if (push) tail_d = (tail_q == LAST_SLOT) ? '0 : tail_q + PTR_WIDTH'(1);
    if (pop_buf) head_d = (head_q == LAST_SLOT) ? '0 : head_q + PTR_WIDTH'(1);
    if (accept) rr_ptr_d = (grant == LAST_INPUT) ? '0 : grant + INDEX_WIDTH'(1);
    count_d = count_q + OCC_WIDTH'(push) - OCC_WIDTH'(pop_buf);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[tail_q] <= grant_data;
      idx_mem_q[tail_q]  <= grant;
    end
  end

`ifdef RR_MERGE_OCCUPANCY_EN
  assign occupancy = count_q;
  assign full_o    = full;
`endif

endmodule

// File: tb/tb_rr_merge_tfifo.sv
// Self-checking bench for rr_merge_tfifo (3 inputs, 2 slots) with an accept-order scoreboard.
module tb_rr_merge_tfifo;
  localparam int N  = 3;
  localparam int S  = 2;
  localparam int DW = 32;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N*DW-1:0] ins;
  logic [N-1:0]    ins_valid, ins_ready;
  logic [DW-1:0]   outs;
  logic [IW-1:0]   outs_index;
  logic            outs_valid, outs_ready;
`ifdef RR_MERGE_OCCUPANCY_EN
  logic [1:0]      occupancy;
  logic            full_o;
`endif

  rr_merge_tfifo #(.NUM_INPUTS(N), .SLOTS(S), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(ins_ready),
    .outs(outs), .outs_index(outs_index), .outs_valid(outs_valid), .outs_ready(outs_ready)
`ifdef RR_MERGE_OCCUPANCY_EN
    , .occupancy(occupancy), .full_o(full_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } tok_t;

  tok_t          sb_q[$];
  tok_t          mon_e;
  logic [DW-1:0] popped_q[$];
  logic [IW-1:0] popidx_q[$];

  // Monitor: accepted tokens enter the scoreboard, popped tokens must match its front.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      sb_q.delete();
    end else begin
      checks++;
      if (!$onehot0(ins_ready)) begin
        errors++;
        $display("FAIL ready_onehot: ins_ready=%b required one-hot or zero", ins_ready);
      end
      for (int i = 0; i < N; i++)
        if (ins_valid[i] && ins_ready[i]) sb_q.push_back({IW'(i), ins[i*DW +: DW]});
      if (outs_valid && outs_ready) begin
        popped_q.push_back(outs);
        popidx_q.push_back(outs_index);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: popped %h idx %0d with nothing accepted", outs, outs_index);
        end else begin
          mon_e = sb_q.pop_front();
          if (outs !== mon_e.data || outs_index !== mon_e.idx) begin
            errors++;
            $display("FAIL sb_order: got %h idx %0d required %h idx %0d", outs, outs_index, mon_e.data, mon_e.idx);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int ch, input logic [DW-1:0] v);
    ins[ch*DW +: DW] = v;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ins_valid = '0;
    outs_ready = 1'b0;
    next_cycle();
    rst = 1'b1;
  endtask

  task automatic fill_two();
    outs_ready = 1'b0;
    set_in(0, 32'h11);
    set_in(1, 32'h22);
    ins_valid = 3'b011;
    next_cycle();
    ins_valid = 3'b010;
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ins_valid = '1;
    outs_ready = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 32'h50 + i);
    next_cycle();
    @(negedge clk);
    checks++;
    if (ins_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b required 000", ins_ready); end
    checks++;
    if (outs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", outs_valid); end
`ifdef RR_MERGE_OCCUPANCY_EN
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ: got %0d required 0", occupancy); end
`endif
    next_cycle();
  endtask

  task automatic test_bypass();
    logic [IW-1:0] ei;
    do_reset();
    set_in(0, 32'hA);
    set_in(1, 32'hB);
    set_in(2, 32'hC);
    ins_valid = 3'b011;
    outs_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      ei = IW'(k % 2);
      @(negedge clk);
      checks++;
      if (outs_valid !== 1'b1 || outs_index !== ei || outs !== (ei == 0 ? 32'hA : 32'hB)) begin
        errors++;
        $display("FAIL bypass_out[%0d]: got v=%b idx=%0d %h required idx=%0d", k, outs_valid, outs_index, outs, ei);
      end
      checks++;
      if (ins_ready !== (3'b001 << ei)) begin errors++; $display("FAIL bypass_ready[%0d]: got %b required %b", k, ins_ready, 3'b001 << ei); end
`ifdef RR_MERGE_OCCUPANCY_EN
      checks++;
      if (occupancy !== 2'd0) begin errors++; $display("FAIL bypass_occ[%0d]: got %0d required 0", k, occupancy); end
`endif
      next_cycle();
    end
    ins_valid = '0;
    outs_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    do_reset();
    outs_ready = 1'b0;
    set_in(0, 32'h11);
    set_in(1, 32'h22);
    ins_valid = 3'b011;
    @(negedge clk);
    checks++;
    if (ins_ready !== 3'b001 || outs !== 32'h11 || outs_valid !== 1'b1) begin
      errors++; $display("FAIL fill_c1: got ready=%b %h v=%b required 001 00000011 1", ins_ready, outs, outs_valid);
    end
    next_cycle();
    ins_valid = 3'b010;
    @(negedge clk);
    checks++;
    if (ins_ready !== 3'b010 || outs !== 32'h11 || outs_index !== 2'd0) begin
      errors++; $display("FAIL fill_c2: got ready=%b %h idx=%0d required 010 00000011 0", ins_ready, outs, outs_index);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ins_ready !== 3'b000 || outs !== 32'h11) begin
      errors++; $display("FAIL fill_full: got ready=%b %h required 000 00000011", ins_ready, outs);
    end
`ifdef RR_MERGE_OCCUPANCY_EN
    checks++;
    if (occupancy !== 2'd2 || full_o !== 1'b1) begin errors++; $display("FAIL fill_occ: got %0d full=%b required 2 1", occupancy, full_o); end
`endif
    next_cycle();
    ins_valid = '0;
    outs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b1 || outs !== 32'h11 || outs_index !== 2'd0) begin
      errors++; $display("FAIL drain_1: got v=%b %h idx=%0d required 1 00000011 0", outs_valid, outs, outs_index);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b1 || outs !== 32'h22 || outs_index !== 2'd1) begin
      errors++; $display("FAIL drain_2: got v=%b %h idx=%0d required 1 00000022 1", outs_valid, outs, outs_index);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got v=%b required 0", outs_valid); end
    next_cycle();
    outs_ready = 1'b0;
  endtask

  task automatic test_full_pop();
    do_reset();
    fill_two();
    ins_valid = 3'b001;
    set_in(0, 32'h33);
    outs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ins_ready !== 3'b001 || outs !== 32'h11) begin
      errors++; $display("FAIL fullpop_accept: got ready=%b %h required 001 00000011", ins_ready, outs);
    end
    next_cycle();
    ins_valid = '0;
    @(negedge clk);
    checks++;
    if (outs !== 32'h22 || outs_index !== 2'd1) begin errors++; $display("FAIL fullpop_2: got %h idx=%0d required 00000022 1", outs, outs_index); end
`ifdef RR_MERGE_OCCUPANCY_EN
    checks++;
    if (occupancy !== 2'd2) begin errors++; $display("FAIL fullpop_occ: got %0d required 2", occupancy); end
`endif
    next_cycle();
    @(negedge clk);
    checks++;
    if (outs !== 32'h33 || outs_index !== 2'd0 || outs_valid !== 1'b1) begin
      errors++; $display("FAIL fullpop_3: got %h idx=%0d v=%b required 00000033 0 1", outs, outs_index, outs_valid);
    end
    next_cycle();
    outs_ready = 1'b0;
  endtask

  task automatic test_fairness();
    logic [IW-1:0] ei;
    do_reset();
    for (int i = 0; i < N; i++) set_in(i, 32'hC0 + i);
    ins_valid = 3'b111;
    outs_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      ei = IW'(k % 3);
      @(negedge clk);
      checks++;
      if (outs_index !== ei || outs !== 32'hC0 + 32'(ei)) begin
        errors++; $display("FAIL fair[%0d]: got idx=%0d %h required idx=%0d", k, outs_index, outs, ei);
      end
      next_cycle();
    end
    ins_valid = '0;
    outs_ready = 1'b0;
  endtask

  task automatic test_wrap_stall();
    int sent = 0;
    int cyc = 0;
    do_reset();
    popped_q.delete();
    popidx_q.delete();
    while (popped_q.size() < 20 && cyc < 200) begin
      set_in(2, 32'h100 + sent);
      ins_valid = (sent < 20) ? 3'b100 : 3'b000;
      outs_ready = (cyc % 2 == 0);
      @(negedge clk);
      if (ins_valid[2] && ins_ready[2]) sent++;
      next_cycle();
      cyc++;
    end
    ins_valid = '0;
    outs_ready = 1'b0;
    checks++;
    if (popped_q.size() != 20) begin
      errors++; $display("FAIL wrap_count: got %0d tokens required 20 (cycles=%0d)", popped_q.size(), cyc);
    end else begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (popped_q[k] !== 32'h100 + k || popidx_q[k] !== 2'd2) begin
          errors++; $display("FAIL wrap_val[%0d]: got %h idx=%0d required %h idx=2", k, popped_q[k], popidx_q[k], 32'h100 + k);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_two();
    rst = 1'b0;
    ins_valid = 3'b111;
    outs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ins_ready !== 3'b000 || outs_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_gate: got ready=%b v=%b required 000 0", ins_ready, outs_valid);
    end
    next_cycle();
    rst = 1'b1;
    ins_valid = '0;
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b0) begin errors++; $display("FAIL midrst_empty: got v=%b required 0", outs_valid); end
`ifdef RR_MERGE_OCCUPANCY_EN
    checks++;
    if (occupancy !== 2'd0) begin errors++; $display("FAIL midrst_occ: got %0d required 0", occupancy); end
`endif
    next_cycle();
    for (int i = 0; i < N; i++) set_in(i, 32'hD0 + i);
    ins_valid = 3'b111;
    @(negedge clk);
    checks++;
    if (ins_ready !== 3'b001 || outs_index !== 2'd0 || outs !== 32'hD0) begin
      errors++; $display("FAIL midrst_rr: got ready=%b idx=%0d %h required 001 0 000000d0", ins_ready, outs_index, outs);
    end
    next_cycle();
    ins_valid = '0;
    outs_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    ins = '0;
    ins_valid = '0;
    outs_ready = 1'b0;
    test_reset();
    test_bypass();
    test_fill_drain();
    test_full_pop();
    test_fairness();
    test_wrap_stall();
    test_reset_mid();
    next_cycle();
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d tokens never emitted, required 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_merge_tfifo.md
Name: rr_merge_tfifo

Overview:
- Round-robin arbiter that shares one transparent FIFO buffer between NUM_INPUTS handshake producers.
- Emits a single merged stream, tagging each token with the index of its source input.
- Sits in front of a shared functional unit or memory port, so several dataflow branches can feed one consumer without deadlocking on back-pressure.
- Bypass is zero-latency while the buffer is empty. Otherwise tokens are buffered in arrival order.

Parameters:
NUM_INPUTS, 2, number of requesting input channels (>=2)
SLOTS, 2, buffer depth in tokens (>=1)
DATA_WIDTH, 32, token payload width
INDEX_WIDTH, derived localparam = max(1, clog2(NUM_INPUTS)), width of source tag

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-low reset (rst=0 resets on the clock edge)
ins  in  NUM_INPUTS*DATA_WIDTH  packed payloads, channel i at bits [i*DATA_WIDTH +: DATA_WIDTH]
ins_valid  in  NUM_INPUTS  per-channel valid
ins_ready  out  NUM_INPUTS  per-channel ready, one-hot or zero
outs  out  DATA_WIDTH  merged payload
outs_index  out  INDEX_WIDTH  source channel of outs
outs_valid  out  1  merged valid
outs_ready  in  1  downstream ready

Behaviour:
- State:
  - rr_ptr: INDEX_WIDTH; highest-priority channel.
  - Circular buffer of SLOTS entries {index, data}, with head, tail and count.
  - count ranges 0..SLOTS; empty = (count==0), full = (count==SLOTS).
- Arbitration (combinational):
  - grant = first channel with ins_valid set, scanning rr_ptr, rr_ptr+1, ... modulo NUM_INPUTS.
  - No valid input means no grant.
- can_accept = !full || outs_ready.
  - A full buffer accepts in the same cycle it pops.
- ins_ready[g] = can_accept for the granted channel g; all other bits are 0.
- Accept event = a grant exists && can_accept.
- Output:
  - When the buffer is non-empty: outs, outs_index and outs_valid=1 come from the head entry.
  - When empty: bypass. outs = ins[grant], outs_index = grant, outs_valid = (grant exists).
- Pop event = outs_valid && outs_ready.
- Buffer update on the clock edge:
  - Empty, accept and pop together: token bypasses; count is unchanged.
  - Empty, accept without pop: token written at tail; count = 1.
  - Non-empty accept: write at tail; tail advances with wrap (SLOTS-1 -> 0).
  - Non-empty pop: head advances with wrap.
  - count += accept_written - popped_from_buffer.
  - Simultaneous write and pop on a full buffer leaves count = SLOTS.
- rr_ptr update: on an accept event, rr_ptr = (grant+1) mod NUM_INPUTS. Otherwise unchanged.
- Ordering: output order equals accept order. No token is dropped or duplicated.
- Stability: once outs_valid is asserted from the buffer, outs and outs_index hold until popped.
- Reset (rst=0 at an edge, including mid-transfer):
  - count=0, head=0, tail=0, rr_ptr=0; buffered tokens are discarded.
  - During reset, ins_ready = 0 and outs_valid = 0 regardless of inputs.
  - First accept is possible in the first cycle with rst=1.
- Latency: 0 cycles through bypass; N cycles when N tokens are ahead in the buffer.
- NUM_INPUTS not a power of two: rr_ptr wraps at NUM_INPUTS-1 -> 0, never reaching unused codes.

Optional Feature:
RR_MERGE_OCCUPANCY_EN
- Defined:
  - Adds output port occupancy, width clog2(SLOTS+1), equal to the registered count; reset value 0.
  - Adds output port full_o (= full), for performance counters and buffer-sizing analysis.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Bypass: all ins_valid=1, outs_ready=1, ins={0xB,0xA} for NUM_INPUTS=2 -> cycle 1 outs=0xA idx=0; cycle 2 outs=0xB idx=1; alternation continues; count stays 0.
- Fill and drain: outs_ready=0, ch0 sends 0x11, ch1 sends 0x22, SLOTS=2.
  - Both are accepted over 2 cycles; then ins_ready=00.
  - Raising outs_ready yields 0x11/idx0 then 0x22/idx1.
- Full with simultaneous pop: buffer full, outs_ready=1, ch0 valid 0x33 -> ins_ready[0]=1 in the same cycle; count stays 2; 0x33 emerges third.
- Fairness: NUM_INPUTS=3, all inputs continuously valid, outs_ready=1 for 9 cycles -> idx sequence 0,1,2,0,1,2,0,1,2.
- Wrap and stall: SLOTS=3, alternate outs_ready 1/0 for 20 tokens from ch2 -> all 20 values are emitted in order with no loss; head/tail wrap at least 6 times.
- Reset mid-operation: 2 tokens buffered, assert rst=0 for 1 cycle -> next cycle outs_valid=0 and occupancy=0 (macro defined); rr_ptr restarts at channel 0.
